usb_host_tx: RTL and testbench
==============================

Name: usb_host_tx

Overview:
- Host-side USB full-speed packet transmitter for the USB test benches: the far end that drives the device-under-test's D+/D- pins.
- Accepts packet bytes over a valid/ready stream and serialises them onto the bus: SYNC, then LSB-first data with bit stuffing, NRZI encoding and EOP.
- Runs on the 48 MHz host clock and oversamples the 12 Mbit/s line 4x.
- The bench connects its outputs through tri-state buffers, gated by usb_tx_en, onto the shared usb_d_p/usb_d_n nets.

Parameters:
CLKS_PER_BIT, 4, clk48_host cycles per USB bit-time; legal range 1..16.
STUFF_LIMIT, 6, consecutive line 1s after which a stuff 0 is inserted.

Ports:
clk48_host  input  1  host clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
tx_valid  input  1  tx_data/tx_last valid.
tx_data  input  8  packet byte, sent LSB first.
tx_last  input  1  marks final byte of packet.
tx_ready  output  1  byte accepted when tx_valid && tx_ready.
usb_d_p_o  output  1  driven D+ level.
usb_d_n_o  output  1  driven D- level.
usb_tx_en  output  1  output enable for D+/D-.
busy  output  1  high from first accept until EOP completes.
underrun  output  1  one-cycle pulse on stream starvation mid-packet.

Behaviour:
- Reset and idle state:
  - usb_d_p_o=1, usb_d_n_o=0 (J), usb_tx_en=0, busy=0, underrun=0.
  - tx_ready=1; holding register empty; stuff counter 0; NRZI level J.
- Internal buffering: one-byte holding register (data + last flag) in front of an 8-bit shifter.
  - tx_ready = !hold_full && !last_accepted.
  - In IDLE the holding register is empty, so tx_ready=1.
- Bit strobe: fires every CLKS_PER_BIT cycles, counted from packet start. Each line symbol is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, SYNC, DATA, ABORT, EOP_SE0, EOP_J.
  - IDLE: first accepted byte goes to the holding register. Next cycle: state=SYNC, usb_tx_en=1, busy=1, and the first SYNC symbol (K) is on the line.
  - SYNC: sends 0x80 LSB first (0,0,0,0,0,0,0,1). Line pattern from J is KJKJKJKK. The final 1 counts toward stuffing (counter=1).
  - DATA: at each byte boundary the shifter loads from the holding register, and tx_ready may reassert in that same cycle.
  - Back-to-back bytes have no idle bit-times between them.
  - After the last bit of the byte flagged last (plus any pending stuff bit), go to EOP_SE0.
  - Byte boundary with holding register empty and last not yet accepted: underrun pulses for 1 cycle, go to ABORT.
  - ABORT: 8 bit-times of 1s with stuffing disabled (line holds current level), then EOP_SE0.
  - EOP_SE0: d_p=d_n=0 for 2 bit-times; stuff counter not applied.
  - EOP_J: J for 1 bit-time. Then usb_tx_en=0, busy=0, NRZI level=J, stuff counter=0, last_accepted cleared, state=IDLE.
- Encoding:
  - NRZI: data 0 toggles the line (J<->K); data 1 holds it.
  - J = (1,0), K = (0,1).
- Stuffing:
  - A 0 is inserted after STUFF_LIMIT consecutive 1s, including when that occurs after the final data bit.
  - The stuff bit resets the counter. Any data 0 resets the counter.
  - While a stuff bit is on the line, the shifter does not advance.
- tx_valid/tx_data/tx_last may change freely while tx_ready=0. Bytes offered after the last byte is accepted are held off (tx_ready=0) until IDLE.
- Single-byte packet: SYNC, byte, EOP all complete normally.
- Reset asserted mid-packet: on the next edge all outputs return to reset values, the line returns to J with usb_tx_en=0, and the holding register is discarded. No EOP is sent.
- Arithmetic widths:
  - Bit-time counter: ceil(log2(CLKS_PER_BIT)) bits, wraps at CLKS_PER_BIT-1.
  - Stuff counter: 3 bits, saturates at STUFF_LIMIT.

Test Plan:
- Single byte 0x2D, tx_last=1:
  - Line is KJKJKJKK, KJJJKKJK, SE0, SE0, J: 19 bit-times, each 4 cycles.
  - usb_tx_en high exactly 76 cycles; tx_ready low from accept until EOP ends.
- Single byte 0xFF, last:
  - Line after SYNC holds K for 5 bit-times, stuff toggles to J, holds J for 3, then SE0 SE0 J.
  - 20 bit-times total (80 cycles).
- Bytes 0xC3, 0x00, 0x5A with tx_valid held high, last on 0x5A:
  - tx_ready handshakes exactly 3 times; no gap bit-times; 35 bit-times total.
  - Decoded NRZI reproduces 0x80, 0xC3, 0x00, 0x5A.
- Byte 0x00 with tx_last=0, then tx_valid=0:
  - underrun pulses 1 cycle at the byte boundary.
  - 8 bit-times with no transitions, then SE0 SE0 J; busy falls after EOP.
- reset asserted at bit-time 10 of a 3-byte packet:
  - Next cycle usb_tx_en=0, line J, busy=0, tx_ready=1.
  - A new 0x2D packet afterwards is identical to the first scenario.
- CLKS_PER_BIT=1 with 0x2D last: same 19-symbol sequence, one cycle per symbol.

Source files
------------

// File: rtl/usb_host_tx.sv
// Host-side USB full-speed transmitter: byte stream in, SYNC + NRZI/bit-stuffed
// data + EOP out on D+/D-, with CLKS_PER_BIT clocks per line symbol.
module usb_host_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk48_host,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_d_p_o,
  output logic       usb_d_n_o,
  output logic       usb_tx_en,
  output logic       busy,
  output logic       underrun
);
  localparam int             BCW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] BC_MAX    = BCW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STUFF_MAX = 3'(STUFF_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_ABORT, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [BCW-1:0] r_bitcnt;
  logic [7:0]     r_shift, r_hold;
  logic [3:0]     r_bitidx;    // bits of the current byte already on the line
  logic [3:0]     r_aux;       // abort / EOP symbol counter
  logic [2:0]     r_stuffcnt;
  logic           r_hold_full, r_hold_last, r_last_acc, r_cur_last;
  logic           r_level;     // NRZI level, 1 = J
  logic           r_dp, r_dn, r_underrun;

  logic w_strobe, w_bound, w_load, w_accept, w_emit, w_data_bit;
  logic w_start, w_stuff, w_adv, w_se0, w_underrun, w_abort_step;
  logic w_eop_again, w_eop_j, w_finish;

  assign w_strobe = (r_state != S_IDLE) && (r_bitcnt == BC_MAX);
  // Byte boundary in SYNC/DATA that is not the end of the packet.
  assign w_bound  = ((r_state == S_SYNC) || (r_state == S_DATA)) && w_strobe &&
                    (r_stuffcnt != STUFF_MAX) && (r_bitidx == 4'd8) && !r_cur_last;
  assign w_load   = w_bound && r_hold_full;
  // New bytes are refused while an aborted packet drains, so IDLE always
  // starts with an empty holding register.
  assign tx_ready = (!r_hold_full || w_load) && !r_last_acc &&
                    ((r_state == S_IDLE) || (r_state == S_SYNC) || (r_state == S_DATA));
  assign w_accept   = tx_valid && tx_ready;
  assign w_emit     = w_adv || w_load;
  assign w_data_bit = w_load ? r_hold[0] : r_shift[0];

  assign usb_d_p_o = r_dp;
  assign usb_d_n_o = r_dn;
  assign usb_tx_en = (r_state != S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign underrun  = r_underrun;

  // State register.
  always_ff @(posedge clk48_host) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-strobe symbol decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_stuff      = 1'b0;
    w_adv        = 1'b0;
    w_se0        = 1'b0;
    w_underrun   = 1'b0;
    w_abort_step = 1'b0;
    w_eop_again  = 1'b0;
    w_eop_j      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_start     = 1'b1;
        w_state_nxt = S_SYNC;
      end
      S_SYNC, S_DATA: if (w_strobe) begin
        if (r_stuffcnt == STUFF_MAX) w_stuff = 1'b1;
        else if (r_bitidx != 4'd8)   w_adv   = 1'b1;
        else if (r_cur_last) begin
          w_se0       = 1'b1;
          w_state_nxt = S_EOP_SE0;
        end else if (r_hold_full) begin
          w_state_nxt = S_DATA;
        end else begin
          w_underrun  = 1'b1;
          w_state_nxt = S_ABORT;
        end
      end
      S_ABORT: if (w_strobe) begin
        if (r_aux == 4'd8) begin
          w_se0       = 1'b1;
          w_state_nxt = S_EOP_SE0;
        end else begin
          w_abort_step = 1'b1;
        end
      end
      S_EOP_SE0: if (w_strobe) begin
        if (r_aux == 4'd0) w_eop_again = 1'b1;
        else begin
          w_eop_j     = 1'b1;
          w_state_nxt = S_EOP_J;
        end
      end
      S_EOP_J: if (w_strobe) begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: bit timer, holding register, shifter, stuffing and line drive.
  always_ff @(posedge clk48_host) begin
    if (reset) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_bitidx    <= '0;
      r_aux       <= '0;
      r_stuffcnt  <= '0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_last_acc  <= 1'b0;
      r_cur_last  <= 1'b0;
      r_level     <= 1'b1;
      r_dp        <= 1'b1;
      r_dn        <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_underrun;

      if (w_start)                r_bitcnt <= '0;
      else if (r_state != S_IDLE) r_bitcnt <= (r_bitcnt == BC_MAX) ? '0 : r_bitcnt + 1'b1;

      if (w_load) r_hold_full <= 1'b0;
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_last <= tx_last;
        r_hold_full <= 1'b1;
        if (tx_last) r_last_acc <= 1'b1;
      end

      // First SYNC bit (a 0) goes out on the accept edge: J -> K.
      if (w_start) begin
        r_shift    <= 8'h40;
        r_bitidx   <= 4'd1;
        r_stuffcnt <= '0;
        r_cur_last <= 1'b0;
        r_level    <= 1'b0;
        r_dp       <= 1'b0;
        r_dn       <= 1'b1;
      end

      // Stuff bit: a forced 0, so toggle; the shifter holds.
      if (w_stuff) begin
        r_level    <= !r_level;
        r_dp       <= !r_level;
        r_dn       <= r_level;
        r_stuffcnt <= '0;
      end

      if (w_emit) begin
        r_shift  <= w_load ? {1'b0, r_hold[7:1]} : {1'b0, r_shift[7:1]};
        r_bitidx <= w_load ? 4'd1 : r_bitidx + 4'd1;
        if (w_load) r_cur_last <= r_hold_last;
        if (w_data_bit) begin
          r_stuffcnt <= (r_stuffcnt == STUFF_MAX) ? r_stuffcnt : r_stuffcnt + 3'd1;
        end else begin
          r_level    <= !r_level;
          r_dp       <= !r_level;
          r_dn       <= r_level;
          r_stuffcnt <= '0;
        end
      end

      // Abort sends 1s unstuffed: the line simply keeps its level.
      if (w_underrun)   r_aux <= 4'd1;
      if (w_abort_step) r_aux <= r_aux + 4'd1;

      if (w_se0) begin
        r_dp  <= 1'b0;
        r_dn  <= 1'b0;
        r_aux <= 4'd0;
      end
      if (w_eop_again) r_aux <= 4'd1;
      if (w_eop_j) begin
        r_dp <= 1'b1;
        r_dn <= 1'b0;
      end
      if (w_finish) begin
        r_level    <= 1'b1;
        r_stuffcnt <= '0;
        r_last_acc <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_usb_host_tx.sv
// Bench for usb_host_tx: directed and random packets compared symbol-by-symbol
// against a line model built from SYNC/stuffing/NRZI/EOP rules.
module tb_usb_host_tx;
  typedef logic [7:0] bq_t[$];
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, rst1, sel1;
  logic       tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       rdy4, dp4, dn4, en4, busy4, und4;
  logic       rdy1, dp1, dn1, en1, busy1, und1;

  usb_host_tx #(.CLKS_PER_BIT(4), .STUFF_LIMIT(6)) dut4 (
    .clk48_host(clk), .reset(rst4), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(rdy4), .usb_d_p_o(dp4), .usb_d_n_o(dn4),
    .usb_tx_en(en4), .busy(busy4), .underrun(und4));

  usb_host_tx #(.CLKS_PER_BIT(1), .STUFF_LIMIT(6)) dut1 (
    .clk48_host(clk), .reset(rst1), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(rdy1), .usb_d_p_o(dp1), .usb_d_n_o(dn1),
    .usb_tx_en(en1), .busy(busy1), .underrun(und1));

  wire m_rdy  = sel1 ? rdy1  : rdy4;
  wire m_dp   = sel1 ? dp1   : dp4;
  wire m_dn   = sel1 ? dn1   : dn4;
  wire m_en   = sel1 ? en1   : en4;
  wire m_busy = sel1 ? busy1 : busy4;
  wire m_und  = sel1 ? und1  : und4;

  int n_cmp = 0, n_err = 0;
  logic [1:0] cap[$];
  logic [1:0] exp_q[$];
  int en_cyc, busy_cyc, und_cyc, hs, rdy_en;
  bq_t pk;

  // Line and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_en) begin
      cap.push_back({m_dp, m_dn});
      en_cyc++;
      if (m_rdy) rdy_en++;
    end
    if (m_busy) busy_cyc++;
    if (m_und) und_cyc++;
    if (tx_valid && m_rdy) hs++;
  end

  task automatic clr();
    cap.delete();
    en_cyc = 0; busy_cyc = 0; und_cyc = 0; hs = 0; rdy_en = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected line symbols: SYNC + bytes LSB first, 0 inserted after six 1s,
  // NRZI from J; abort appends 8 unchanged symbols; then SE0 SE0 J.
  task automatic build_exp(input bq_t b, input bit abort);
    bit bits[$];
    logic [1:0] lvl;
    int ones;
    exp_q.delete();
    for (int k = 0; k < 8; k++) bits.push_back(k == 7);
    foreach (b[i]) for (int k = 0; k < 8; k++) bits.push_back(b[i][k]);
    lvl = J; ones = 0;
    foreach (bits[i]) begin
      if (bits[i]) ones++;
      else begin lvl = (lvl == J) ? K : J; ones = 0; end
      exp_q.push_back(lvl);
      if (ones == 6) begin
        lvl = (lvl == J) ? K : J; ones = 0;
        exp_q.push_back(lvl);
      end
    end
    if (abort) for (int k = 0; k < 8; k++) exp_q.push_back(lvl);
    exp_q.push_back(SE0); exp_q.push_back(SE0); exp_q.push_back(J);
  endtask

  task automatic send(input string tag, input bq_t b, input bit last_flag);
    for (int i = 0; i < b.size(); i++) begin
      int t = 0;
      bit ok = 1'b0;
      tx_valid = 1'b1;
      tx_data  = b[i];
      tx_last  = last_flag && (i == b.size() - 1);
      while (!ok && t < 500) begin
        @(negedge clk);
        if (m_rdy) ok = 1'b1;
        t++;
      end
      if (!ok) chk({tag, " accept_timeout"}, 32'(ok), 32'd1);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (m_busy && t < 3000) begin @(negedge clk); t++; end
    chk({tag, " busy_fall"}, 32'(m_busy), 32'd0);
  endtask

  task automatic run_pkt(input string tag, input bq_t b, input bit last_flag,
                         input int cpb);
    int nsym;
    bit bad;
    clr();
    build_exp(b, !last_flag);
    send(tag, b, last_flag);
    wait_done(tag);
    @(posedge clk); #1;
    nsym = exp_q.size() * cpb;
    chk({tag, " en_cycles"},   32'(en_cyc),   32'(nsym));
    chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(nsym));
    chk({tag, " handshakes"},  32'(hs),       32'(b.size()));
    chk({tag, " underrun"},    32'(und_cyc),  last_flag ? 32'd0 : 32'd1);
    if (b.size() == 1 && last_flag) chk({tag, " ready_while_busy"}, 32'(rdy_en), 32'd0);
    bad = 1'b0;
    for (int j = 0; j < nsym && j < cap.size() && !bad; j++) begin
      n_cmp++;
      assert (cap[j] === exp_q[j / cpb]) else begin
        n_err++;
        bad = 1'b1;
        $error("FAIL %s line: cycle %0d got %b want %b", tag, j, cap[j], exp_q[j / cpb]);
      end
    end
    chk({tag, " idle_line"},  32'({m_dp, m_dn}), 32'(J));
    chk({tag, " idle_ready"}, 32'(m_rdy), 32'd1);
  endtask

  initial begin
    rst4 = 1'b1; rst1 = 1'b1; sel1 = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst4 = 1'b0;
    @(negedge clk);
    chk("rst dp",    32'(m_dp),   32'd1);
    chk("rst dn",    32'(m_dn),   32'd0);
    chk("rst en",    32'(m_en),   32'd0);
    chk("rst busy",  32'(m_busy), 32'd0);
    chk("rst und",   32'(m_und),  32'd0);
    chk("rst ready", 32'(m_rdy),  32'd1);
    @(posedge clk); #1;

    pk.delete(); pk.push_back(8'h2D);
    run_pkt("b2d", pk, 1'b1, 4);
    pk.delete(); pk.push_back(8'hFF);
    run_pkt("bff", pk, 1'b1, 4);
    pk.delete(); pk.push_back(8'hFC);
    run_pkt("bfc_tailstuff", pk, 1'b1, 4);
    pk.delete(); pk.push_back(8'hC3); pk.push_back(8'h00); pk.push_back(8'h5A);
    run_pkt("three", pk, 1'b1, 4);
    pk.delete(); pk.push_back(8'h00);
    run_pkt("underrun", pk, 1'b0, 4);

    // Reset mid-packet at bit-time 10.
    begin
      int t = 0;
      clr();
      pk.delete(); pk.push_back(8'hC3); pk.push_back(8'h00);
      send("rst_mid", pk, 1'b0);
      tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b1;
      while (en_cyc < 40 && t < 500) begin @(negedge clk); t++; end
      chk("rst_mid reach_bt10", 32'(en_cyc >= 40), 32'd1);
      @(posedge clk); #1;
      rst4 = 1'b1; tx_valid = 1'b0; tx_last = 1'b0;
      @(posedge clk); #1;
      rst4 = 1'b0;
      @(negedge clk);
      chk("rst_mid en",    32'(m_en),          32'd0);
      chk("rst_mid line",  32'({m_dp, m_dn}),  32'(J));
      chk("rst_mid busy",  32'(m_busy),        32'd0);
      chk("rst_mid ready", 32'(m_rdy),         32'd1);
      @(posedge clk); #1;
    end
    pk.delete(); pk.push_back(8'h2D);
    run_pkt("b2d_after_rst", pk, 1'b1, 4);

    // Random packets, valid held high across bytes.
    for (int p = 0; p < 8; p++) begin
      int n = $urandom_range(1, 4);
      pk.delete();
      for (int i = 0; i < n; i++) pk.push_back(8'($urandom_range(0, 255)));
      run_pkt($sformatf("rnd%0d", p), pk, 1'b1, 4);
    end

    // One clock per symbol.
    rst4 = 1'b1; sel1 = 1'b1;
    @(posedge clk); #1 rst1 = 1'b0;
    @(posedge clk); #1;
    pk.delete(); pk.push_back(8'h2D);
    run_pkt("cpb1_b2d", pk, 1'b1, 1);
    pk.delete(); pk.push_back(8'hFF); pk.push_back(8'h81);
    run_pkt("cpb1_ff81", pk, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
